// File: rtl/i8008_pkg.sv
// i8008_pkg: shared types and defaults for the i8008 core and its bus interface.
package i8008_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 14;
    typedef enum logic [2:0] {
        WAIT    = 3'b000,
        T2      = 3'b001,
        T1      = 3'b010,
        T1I     = 3'b011,
        T3      = 3'b100,
        T5      = 3'b101,
        STOPPED = 3'b110,
        T4      = 3'b111
    } state_t;
    typedef enum logic [1:0] {
        PCI = 2'b00,
        PCC = 2'b01,
        PCR = 2'b10,
        PCW = 2'b11
    } cycle_t;
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RD_REQ,
        RD_DONE,
        WR_WAIT,
        WR_REQ
    } bus_state_t;
    function automatic logic is_read(cycle_t c);
        return c == PCI || c == PCR;
    endfunction
endpackage

// File: rtl/i8008_addr_latch.sv
// i8008_addr_latch: low/high address and cycle-type registers with a shadow copy
// that parks the next cycle's address while a write is still outstanding.
module i8008_addr_latch import i8008_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  ld_lo,
    input  logic                  ld_hi,
    input  logic                  hold,
    input  logic                  apply,
    output logic [ADDR_WIDTH-1:0] addr,
    output cycle_t                cyc,
    output cycle_t                sh_cyc,
    output logic                  sh_lo_v,
    output logic                  sh_hi_v
);
    localparam int HW = ADDR_WIDTH - WIDTH;
    logic [WIDTH-1:0] lo, sh_lo;
    logic [HW-1:0] hi, sh_hi;
    cycle_t din_cyc;
    assign din_cyc = cycle_t'(din[WIDTH-1 -: 2]);
    assign addr = {hi, lo};
    always_ff @(posedge clk) begin
        if (rst) begin
            lo <= '0;
            hi <= '0;
            cyc <= PCI;
            sh_lo <= '0;
            sh_hi <= '0;
            sh_cyc <= PCI;
            sh_lo_v <= 1'b0;
            sh_hi_v <= 1'b0;
        end else begin
            if (ld_lo && hold) begin
                sh_lo <= din;
                sh_lo_v <= 1'b1;
            end else if (ld_lo) lo <= din;
            else if (apply && sh_lo_v) lo <= sh_lo;
            if (ld_hi && hold) begin
                sh_hi <= din[HW-1:0];
                sh_cyc <= din_cyc;
                sh_hi_v <= 1'b1;
            end else if (ld_hi) begin
                hi <= din[HW-1:0];
                cyc <= din_cyc;
            end else if (apply && sh_hi_v) begin
                hi <= sh_hi;
                cyc <= sh_cyc;
            end
            if (apply) begin
                sh_lo_v <= 1'b0;
                sh_hi_v <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/i8008_bus_if.sv
// i8008_bus_if: turns the core's multiplexed T-state bus into memory read/write
// requests and I/O strobes, throttling the core through READY.
module i8008_bus_if import i8008_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      D_out,
    input  logic                  Sync,
    input  state_t                state,
    output logic [WIDTH-1:0]      D_in,
    output logic                  READY,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ack,
    output logic                  io_valid,
    output logic [WIDTH-1:0]      io_addr,
    output logic [WIDTH-1:0]      io_data
);
    bus_state_t fsm, fsm_nx;
    cycle_t cyc, sh_cyc, d_cyc;
    logic ld_lo, ld_hi, t3, sh_lo_v, sh_hi_v, io_q;
    logic [WIDTH-1:0] rdata_q, wdata_q;
    assign ld_lo = Sync && (state == T1 || state == T1I);
    assign ld_hi = Sync && state == T2;
    assign t3 = state == T3;
    assign d_cyc = cycle_t'(D_out[WIDTH-1 -: 2]);
    i8008_addr_latch #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_latch (
        .clk(clk),
        .rst(rst),
        .din(D_out),
        .ld_lo(ld_lo),
        .ld_hi(ld_hi),
        .hold(fsm == WR_REQ && !mem_ack),
        .apply(fsm == WR_REQ && mem_ack),
        .addr(mem_addr),
        .cyc(cyc),
        .sh_cyc(sh_cyc),
        .sh_lo_v(sh_lo_v),
        .sh_hi_v(sh_hi_v)
    );
    // On write completion, resume whatever cycle the core started meanwhile.
    always_comb begin
        fsm_nx = fsm;
        unique case (fsm)
            IDLE:    fsm_nx = ld_lo ? ADDR : IDLE;
            ADDR:    fsm_nx = ld_hi ? (is_read(d_cyc) ? RD_REQ : WR_WAIT) : ADDR;
            RD_REQ:  fsm_nx = mem_ack ? RD_DONE : RD_REQ;
            RD_DONE: fsm_nx = t3 ? IDLE : RD_DONE;
            WR_WAIT: fsm_nx = t3 ? (cyc == PCW ? WR_REQ : IDLE) : WR_WAIT;
            WR_REQ:  fsm_nx = !mem_ack ? WR_REQ :
                              ld_hi ? (is_read(d_cyc) ? RD_REQ : WR_WAIT) :
                              ld_lo ? ADDR :
                              sh_hi_v ? (is_read(sh_cyc) ? RD_REQ : WR_WAIT) :
                              sh_lo_v ? ADDR : IDLE;
            default: fsm_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
            rdata_q <= '0;
            wdata_q <= '0;
            io_q <= 1'b0;
        end else begin
            fsm <= fsm_nx;
            if (fsm == RD_REQ && mem_ack) rdata_q <= mem_rdata;
            if (fsm == WR_WAIT && t3) wdata_q <= D_out;
            io_q <= fsm == WR_WAIT && t3 && cyc == PCC;
        end
    end
    assign READY = fsm == RD_DONE || fsm == WR_WAIT;
    assign mem_rd = fsm == RD_REQ;
    assign mem_wr = fsm == WR_REQ;
    assign D_in = fsm == RD_DONE ? rdata_q : '0;
    assign mem_wdata = wdata_q;
    assign io_valid = io_q;
    assign io_addr = mem_addr[WIDTH-1:0];
    assign io_data = wdata_q;
endmodule

// File: tb/tb_i8008_bus_if.sv
// tb_i8008_bus_if: directed bus-cycle vectors against hand-computed expectations.
module tb_i8008_bus_if;
    import i8008_pkg::*;
    logic clk = 1'b0, rst = 1'b1, Sync = 1'b0, mem_ack = 1'b0;
    logic [7:0] D_out = '0, mem_rdata = '0;
    state_t state = T4;
    logic [7:0] D_in, mem_wdata, io_addr, io_data;
    logic [13:0] mem_addr;
    logic READY, mem_rd, mem_wr, io_valid;
    int vec_cnt = 0, err_cnt = 0;

    i8008_bus_if dut (
        .clk(clk), .rst(rst), .D_out(D_out), .Sync(Sync), .state(state),
        .D_in(D_in), .READY(READY), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .io_valid(io_valid), .io_addr(io_addr), .io_data(io_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input state_t st, input logic sy, input logic [7:0] d);
        state = st;
        Sync = sy;
        D_out = d;
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_ready", READY, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_wr", mem_wr, 0);
        check("rst_io", io_valid, 0);
        check("rst_din", D_in, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst = 1'b0;

        drive(T1, 1, 8'h34);
        check("pci_lo", mem_addr, 14'h0034);
        check("pci_addr_ready", READY, 0);
        drive(T2, 1, 8'h12);
        check("pci_addr", mem_addr, 14'h1234);
        check("pci_rd", mem_rd, 1);
        drive(WAIT, 0, 8'h00);
        drive(WAIT, 0, 8'h00);
        mem_ack = 1'b1;
        mem_rdata = 8'h08;
        check("pci_ready_at_ack", READY, 0);
        check("pci_rd_held", mem_rd, 1);
        tick();
        mem_ack = 1'b0;
        check("pci_ready", READY, 1);
        check("pci_rd_drop", mem_rd, 0);
        state = T3;
        #1;
        check("pci_din_t3", D_in, 8'h08);
        tick();
        check("pci_din_clr", D_in, 0);
        check("pci_ready_clr", READY, 0);

        drive(T1, 1, 8'hFF);
        check("pcw_lo", mem_addr, 14'h12FF);
        drive(T2, 1, 8'hC5);
        check("pcw_addr", mem_addr, 14'h05FF);
        check("pcw_ready", READY, 1);
        check("pcw_wr_early", mem_wr, 0);
        drive(T3, 0, 8'hA5);
        check("pcw_wr", mem_wr, 1);
        check("pcw_wdata", mem_wdata, 8'hA5);
        check("pcw_ready_req", READY, 0);
        drive(T4, 0, 8'h00);
        drive(T5, 0, 8'h00);
        check("pcw_wr_held", mem_wr, 1);
        check("pcw_no_rd", mem_rd, 0);
        check("pcw_addr_held", mem_addr, 14'h05FF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("pcw_done", mem_wr, 0);

        drive(T1, 1, 8'h22);
        drive(T2, 1, 8'h40);
        check("pcc_ready", READY, 1);
        drive(T3, 0, 8'h3C);
        check("pcc_io", io_valid, 1);
        check("pcc_data", io_data, 8'h3C);
        check("pcc_ioaddr", io_addr, 8'h22);
        check("pcc_no_rdwr", {mem_rd, mem_wr}, 0);
        drive(T4, 0, 8'h00);
        check("pcc_pulse", io_valid, 0);
        check("pcc_no_rdwr2", {mem_rd, mem_wr}, 0);

        drive(T1, 1, 8'h80);
        drive(T2, 1, 8'hC3);
        drive(T3, 0, 8'h5A);
        check("pend_wr", mem_wr, 1);
        drive(T1, 1, 8'h10);
        check("pend_addr_hold", mem_addr, 14'h0380);
        check("pend_ready", READY, 0);
        drive(T2, 1, 8'h07);
        check("pend_addr_hold2", mem_addr, 14'h0380);
        drive(WAIT, 0, 8'h00);
        check("pend_ready2", READY, 0);
        check("pend_wr2", mem_wr, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("pend_new_addr", mem_addr, 14'h0710);
        check("pend_rd", mem_rd, 1);
        check("pend_wr_off", mem_wr, 0);
        check("pend_ready3", READY, 0);
        mem_ack = 1'b1;
        mem_rdata = 8'h77;
        tick();
        mem_ack = 1'b0;
        check("pend_fetch_ready", READY, 1);
        check("pend_fetch_din", D_in, 8'h77);
        drive(T3, 0, 8'h00);

        drive(T1, 1, 8'h55);
        drive(T2, 1, 8'h8A);
        check("rrst_addr", mem_addr, 14'h0A55);
        check("rrst_rd", mem_rd, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rrst_rd_off", mem_rd, 0);
        check("rrst_addr0", mem_addr, 0);
        check("rrst_wdata0", mem_wdata, 0);
        state = WAIT;
        Sync = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 8'hEE;
        tick();
        mem_ack = 1'b0;
        check("late_ack_ready", READY, 0);
        check("late_ack_din", D_in, 0);
        check("late_ack_rdwr", {mem_rd, mem_wr}, 0);

        drive(T1, 1, 8'h01);
        drive(T2, 1, 8'h3F);
        check("zl_addr", mem_addr, 14'h3F01);
        check("zl_rd", mem_rd, 1);
        mem_ack = 1'b1;
        mem_rdata = 8'h99;
        state = WAIT;
        Sync = 1'b0;
        tick();
        mem_ack = 1'b0;
        check("zl_ready", READY, 1);
        check("zl_din", D_in, 8'h99);
        drive(T3, 0, 8'h00);

        drive(T1, 1, 8'h00);
        drive(T2, 1, 8'hC0);
        drive(STOPPED, 0, 8'h11);
        check("stop_ready", READY, 1);
        check("stop_wdata", mem_wdata, 0);
        drive(T3, 0, 8'h11);
        check("stop_wr", mem_wr, 1);
        check("stop_wdata2", mem_wdata, 8'h11);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stop_done", mem_wr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/i8008_bus_if.md
I8008_BUS_IF -- requirements
Module: i8008_bus_if

Interface
REQ-001 Parameter: WIDTH, 8, data bus width; shall equal the core's WIDTH.
REQ-002 Parameter: ADDR_WIDTH, 14, memory address width (8 low + 6 high bits).
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: D_out  input  WIDTH  multiplexed address/data byte driven by i8008_core.
REQ-006 Port: Sync  input  1  core Sync output.
REQ-007 Port: state  input  state_t  core bus-cycle state (T1, T1I, T2, WAIT, T3, STOPPED, T4, T5).
REQ-008 Port: D_in  output  WIDTH  byte presented to the core during T3.
REQ-009 Port: READY  output  1  ready to the core; low inserts WAIT states.
REQ-010 Port: mem_addr  output  ADDR_WIDTH  latched memory/I/O address.
REQ-011 Port: mem_rd / mem_wr  output  1 each  memory read / write request, level held until mem_ack.
REQ-012 Port: mem_wdata  output  WIDTH  write data captured in T3.
REQ-013 Port: mem_rdata  input  WIDTH  read data, valid with mem_ack.
REQ-014 Port: mem_ack  input  1  one-cycle completion strobe from memory.
REQ-015 Port: io_valid  output  1  one-cycle strobe for PCC (I/O) cycles; io_addr = mem_addr[7:0], io_data = mem_wdata.

Function
REQ-016 Cycle types shall be decoded from D_out[7:6] captured in T2: 00 PCI (fetch), 10 PCR (read), 11 PCW (write), 01 PCC (I/O).
REQ-017 mem_addr[7:0] shall load D_out on every clock with state T1 or T1I and Sync high; mem_addr[13:8] shall load D_out[5:0] on T2 with Sync high.
REQ-018 FSM states: IDLE, ADDR, RD_REQ, RD_DONE, WR_WAIT, WR_REQ.
REQ-019 IDLE->ADDR on low-address capture; ADDR->RD_REQ (PCI/PCR) or WR_WAIT (PCW/PCC) on high-address capture.
REQ-020 RD_REQ: mem_rd=1 until mem_ack; on mem_ack, D_in loads mem_rdata and FSM enters RD_DONE.
REQ-021 READY shall be 1 in RD_DONE and WR_WAIT, else 0; read latency from mem_ack to READY = 1 clock.
REQ-022 RD_DONE shall hold D_in stable until state leaves T3, then go to IDLE.
REQ-023 WR_WAIT: on first T3 clock, mem_wdata loads D_out; PCW goes to WR_REQ, PCC pulses io_valid for 1 clock and returns to IDLE.
REQ-024 WR_REQ: mem_wr=1 until mem_ack, then IDLE; mem_rd and mem_wr shall never both be 1.
REQ-025 If T1 arrives while in WR_REQ, the new low address shall be held in a shadow register, applied on mem_ack, and READY for that new cycle withheld until the write completes.
REQ-026 mem_ack outside RD_REQ/WR_REQ shall be ignored.
REQ-027 STOPPED and T4/T5 shall not alter FSM state or latched registers.
REQ-028 D_in shall be 0 outside RD_DONE.

Reset
REQ-029 On rst, the next edge shall force: FSM IDLE, READY 0, mem_rd 0, mem_wr 0, io_valid 0, D_in 0, mem_addr 0, mem_wdata 0, shadow cleared.
REQ-030 Reset during RD_REQ/WR_REQ shall abandon the request; a late mem_ack after reset shall be ignored.

Structure
REQ-031 cycle_t (PCI, PCR, PCC, PCW), the FSM state enum and ADDR_WIDTH default shall live in the shared i8008 package beside state_t.
REQ-032 One sub-module, i8008_addr_latch (low/high/shadow address registers), is natural; FSM stays in i8008_bus_if.

Verification
REQ-033 PCI fetch: T1 D_out=8'h34, T2 D_out=8'h12, mem_ack after 3 clocks with rdata=8'h08 -> mem_addr=14'h1234, READY 1 clock after ack, D_in=8'h08 in T3.
REQ-034 PCW: T1 8'hFF, T2 8'hC5, T3 D_out=8'hA5 -> mem_wr with mem_addr=14'h05FF, mem_wdata=8'hA5, held until ack.
REQ-035 PCC: T2 8'h40, T3 D_out=8'h3C -> io_valid single pulse, io_data=8'h3C, mem_rd/mem_wr stay 0.
REQ-036 Pending write plus new T1: PCW unacked, next PCI T1 8'h10 -> READY stays 0 until write ack; fetch then addresses the new location.
REQ-037 rst asserted in RD_REQ, then mem_ack -> all outputs 0, FSM IDLE, ack ignored.
REQ-038 Zero-latency memory (mem_ack same clock as mem_rd) -> READY next clock, no WAIT state seen by core.
